// File: rtl/deglitch_scan_ctrl_if.sv
// Bus bundle for the deglitch scan controller: scan enable, raw inputs,
// filter-time configuration port and the filtered/status outputs.
interface deglitch_scan_ctrl_if #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = 3
);
  logic              en;
  logic [NUM_CH-1:0] in;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [15:0]       cfg_filter;
  logic [NUM_CH-1:0] out;
  logic [NUM_CH-1:0] chg;
  logic [CH_W-1:0]   scan_ch;
  logic              scan_wrap;

  modport master (
    output en, in, cfg_wr, cfg_ch, cfg_filter,
    input  out, chg, scan_ch, scan_wrap
  );

  modport slave (
    input  en, in, cfg_wr, cfg_ch, cfg_filter,
    output out, chg, scan_ch, scan_wrap
  );
endinterface

// File: rtl/deglitch_scan_ctrl.sv
// Time-multiplexed deglitch scheduler for drive status inputs. A single
// compare/increment engine visits one channel per clock in round-robin order;
// a channel output follows its synchronized input only after filt+1
// consecutive mismatching visits. Per-channel filter times are host-writable.
module deglitch_scan_ctrl #(
  parameter int          NUM_CH      = 8,
  parameter logic [15:0] FILTER_TIME = 16'd5,
  parameter int          CH_W        = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  deglitch_scan_ctrl_if.slave bus
);

  localparam int              IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] ONE_CH   = CH_W'(1);
  localparam logic [CH_W:0]   NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0] sync1_r;
  logic [NUM_CH-1:0] sync2_r;
  logic [NUM_CH-1:0] out_r;
  logic [NUM_CH-1:0] chg_r;
  logic [CH_W-1:0]   scan_ch_r;
  logic              scan_wrap_r;
  logic [15:0]       filt_r [NUM_CH];
  logic [15:0]       cnt_r  [NUM_CH];

  logic [IDX_W-1:0]  svc_idx_s;
  logic [IDX_W-1:0]  cfg_idx_s;
  logic              svc_sync_s;
  logic              svc_out_s;
  logic [15:0]       svc_cnt_s;
  logic [15:0]       svc_filt_s;
  logic              cfg_ok_s;
  logic              cfg_hit_s;
  logic              svc_en_s;

  // Select the serviced channel's state and decide whether config overrides it.
  always_comb begin
    svc_idx_s  = scan_ch_r[IDX_W-1:0];
    cfg_idx_s  = bus.cfg_ch[IDX_W-1:0];
    svc_sync_s = sync2_r[svc_idx_s];
    svc_out_s  = out_r[svc_idx_s];
    svc_cnt_s  = cnt_r[svc_idx_s];
    svc_filt_s = filt_r[svc_idx_s];
    cfg_ok_s   = bus.cfg_wr && ({1'b0, bus.cfg_ch} < NUM_CH_L);
    cfg_hit_s  = cfg_ok_s && (bus.cfg_ch == scan_ch_r);
    svc_en_s   = bus.en && !cfg_hit_s;
  end

  // Two-flop synchronizer on every raw input; runs regardless of en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= {NUM_CH{1'b0}};
      sync2_r <= {NUM_CH{1'b0}};
    end else begin
      sync1_r <= bus.in;
      sync2_r <= sync1_r;
    end
  end

  // Round-robin scan pointer and wrap pulse, frozen while en is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_ch_r   <= {CH_W{1'b0}};
      scan_wrap_r <= 1'b0;
    end else if (bus.en) begin
      scan_ch_r   <= (scan_ch_r == LAST_CH) ? {CH_W{1'b0}} : scan_ch_r + ONE_CH;
      scan_wrap_r <= (scan_ch_r == LAST_CH);
    end else begin
      scan_wrap_r <= 1'b0;
    end
  end

  // Shared filter engine for the serviced channel plus filter-time writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_r <= {NUM_CH{1'b0}};
      chg_r <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        filt_r[i] <= FILTER_TIME;
        cnt_r[i]  <= 16'd0;
      end
    end else begin
      chg_r <= {NUM_CH{1'b0}};
      if (svc_en_s) begin
        if (svc_sync_s == svc_out_s) begin
          cnt_r[svc_idx_s] <= 16'd0;
        end else if (svc_cnt_s < svc_filt_s) begin
          cnt_r[svc_idx_s] <= svc_cnt_s + 16'd1;
        end else begin
          out_r[svc_idx_s] <= svc_sync_s;
          cnt_r[svc_idx_s] <= 16'd0;
          chg_r[svc_idx_s] <= 1'b1;
        end
      end
      // A write to the serviced channel suppressed its visit above, so this
      // clear is the only update that channel sees this clock.
      if (cfg_ok_s) begin
        filt_r[cfg_idx_s] <= bus.cfg_filter;
        cnt_r[cfg_idx_s]  <= 16'd0;
      end
    end
  end

  assign bus.out       = out_r;
  assign bus.chg       = chg_r;
  assign bus.scan_ch   = scan_ch_r;
  assign bus.scan_wrap = scan_wrap_r;

endmodule

// File: tb/tb_deglitch_scan_ctrl.sv
// Directed bench for deglitch_scan_ctrl with NUM_CH=8, filt=5 and a 4-bit
// channel index so out-of-range config writes can be exercised.
module tb_deglitch_scan_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   passed = 0;
  int   exp_scan = 0;

  always #5 clk = ~clk;

  deglitch_scan_ctrl_if #(.NUM_CH(8), .CH_W(4)) dut_if ();

  deglitch_scan_ctrl #(
    .NUM_CH(8),
    .FILTER_TIME(16'd5),
    .CH_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(dut_if)
  );

  // Advance to the next falling edge and track the expected scan position.
  task automatic tick();
    @(negedge clk);
    if (reset_n && dut_if.en) exp_scan = (exp_scan == 7) ? 0 : exp_scan + 1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_reset(input logic [7:0] in_val);
    dut_if.in = in_val;
    dut_if.en = 1'b1;
    dut_if.cfg_wr = 1'b0;
    dut_if.cfg_ch = 4'd0;
    dut_if.cfg_filter = 16'd0;
    #2 reset_n = 1'b0;
    exp_scan = 0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    dut_if.in = 8'hFF;
    dut_if.en = 1'b1;
    dut_if.cfg_wr = 1'b0;
    dut_if.cfg_ch = 4'd0;
    dut_if.cfg_filter = 16'd0;
    reset_n = 1'b0;
    exp_scan = 0;
    #3;
    checks++; if (dut_if.out !== 8'h00) $display("FAIL reset_out: got %h expected 00", dut_if.out); else passed++;
    checks++; if (dut_if.chg !== 8'h00) $display("FAIL reset_chg: got %h expected 00", dut_if.chg); else passed++;
    checks++; if (dut_if.scan_ch !== 4'd0) $display("FAIL reset_scan_ch: got %0d expected 0", dut_if.scan_ch); else passed++;
    checks++; if (dut_if.scan_wrap !== 1'b0) $display("FAIL reset_scan_wrap: got %b expected 0", dut_if.scan_wrap); else passed++;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // in=FF from reset: channels 2..7 toggle at edges 43..48, ch0 at 49, ch1 at 50.
  task automatic test_power_up_filter();
    int first = 0;
    int pulses = 0;
    int wraps = 0;
    int wrap_bad = 0;
    int scan_bad = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == 48) begin
        checks++; if (dut_if.out !== 8'hFC) $display("FAIL pu_out_e48: got %h expected fc", dut_if.out); else passed++;
      end
      if (n == 49) begin
        checks++; if (dut_if.chg !== 8'h01) $display("FAIL pu_chg_e49: got %h expected 01", dut_if.chg); else passed++;
      end
      if (first == 0 && dut_if.out[0] === 1'b1) first = n;
      if (dut_if.chg[0] === 1'b1) pulses++;
      if (dut_if.scan_wrap === 1'b1) begin
        wraps++;
        if (dut_if.scan_ch !== 4'd0) wrap_bad++;
      end
      if (dut_if.scan_ch !== 4'(exp_scan)) scan_bad++;
    end
    checks++; if (first != 49) $display("FAIL pu_out0_edge: got %0d expected 49", first); else passed++;
    checks++; if (pulses != 1) $display("FAIL pu_chg0_pulses: got %0d expected 1", pulses); else passed++;
    checks++; if (wraps != 7) $display("FAIL pu_wrap_count: got %0d expected 7", wraps); else passed++;
    checks++; if (wrap_bad != 0) $display("FAIL pu_wrap_align: got %0d misaligned expected 0", wrap_bad); else passed++;
    checks++; if (scan_bad != 0) $display("FAIL pu_scan_seq: got %0d bad slots expected 0", scan_bad); else passed++;
  endtask

  // Three short pulses on ch3, each seen on at most 3 visits: never filtered through.
  task automatic test_glitch_reject();
    logic [7:0] chg_or;
    apply_reset(8'h00);
    ticks(4);
    chg_or = 8'h00;
    repeat (3) begin
      dut_if.in[3] = 1'b1;
      repeat (20) begin tick(); chg_or = chg_or | dut_if.chg; end
      dut_if.in[3] = 1'b0;
      repeat (30) begin tick(); chg_or = chg_or | dut_if.chg; end
    end
    checks++; if (dut_if.out !== 8'h00) $display("FAIL glitch_out: got %h expected 00", dut_if.out); else passed++;
    checks++; if (chg_or !== 8'h00) $display("FAIL glitch_chg: got %h expected 00", chg_or); else passed++;
  endtask

  // filt=0 on ch2: out follows on the first ch2 visit after the synchronizer.
  task automatic test_zero_filter();
    int s0;
    int exp_first;
    int got;
    logic [7:0] chg_at;
    logic lvl;
    dut_if.cfg_wr = 1'b1;
    dut_if.cfg_ch = 4'd2;
    dut_if.cfg_filter = 16'd0;
    tick();
    dut_if.cfg_wr = 1'b0;
    for (int ph = 0; ph < 2; ph++) begin
      lvl = (ph == 0) ? 1'b1 : 1'b0;
      s0 = exp_scan;
      exp_first = 0;
      for (int k = 3; k <= 10; k++)
        if (exp_first == 0 && ((s0 + k - 1) % 8) == 2) exp_first = k;
      dut_if.in[2] = lvl;
      got = 0;
      chg_at = 8'h00;
      for (int n = 1; n <= 12; n++) begin
        tick();
        if (got == 0 && dut_if.out[2] === lvl) begin got = n; chg_at = dut_if.chg; end
      end
      checks++; if (got != exp_first) $display("FAIL zf_edge_ph%0d: got %0d expected %0d", ph, got, exp_first); else passed++;
      checks++; if (chg_at !== 8'h04) $display("FAIL zf_chg_ph%0d: got %h expected 04", ph, chg_at); else passed++;
    end
  endtask

  // Config write lands on ch6's toggle visit (edge 47): toggle moves to edge 95.
  task automatic test_cfg_collision();
    apply_reset(8'h40);
    ticks(46);
    checks++; if (dut_if.scan_ch !== 4'd6) $display("FAIL col_scan_ch: got %0d expected 6", dut_if.scan_ch); else passed++;
    dut_if.cfg_wr = 1'b1;
    dut_if.cfg_ch = 4'd6;
    dut_if.cfg_filter = 16'd5;
    tick();
    dut_if.cfg_wr = 1'b0;
    checks++; if (dut_if.out !== 8'h00) $display("FAIL col_out_e47: got %h expected 00", dut_if.out); else passed++;
    checks++; if (dut_if.chg !== 8'h00) $display("FAIL col_chg_e47: got %h expected 00", dut_if.chg); else passed++;
    ticks(47);
    checks++; if (dut_if.out !== 8'h00) $display("FAIL col_out_e94: got %h expected 00", dut_if.out); else passed++;
    tick();
    checks++; if (dut_if.out !== 8'h40) $display("FAIL col_out_e95: got %h expected 40", dut_if.out); else passed++;
    checks++; if (dut_if.chg !== 8'h40) $display("FAIL col_chg_e95: got %h expected 40", dut_if.chg); else passed++;
  endtask

  // en low for 50 clks after ch5 reached cnt=3: toggle slides from edge 46 to 96.
  task automatic test_en_freeze();
    int bad = 0;
    logic [7:0] chg_or = 8'h00;
    logic wrap_or = 1'b0;
    apply_reset(8'h20);
    ticks(24);
    dut_if.en = 1'b0;
    repeat (50) begin
      tick();
      if (dut_if.scan_ch !== 4'd0) bad++;
      if (dut_if.out !== 8'h00) bad++;
      chg_or = chg_or | dut_if.chg;
      wrap_or = wrap_or | dut_if.scan_wrap;
    end
    dut_if.en = 1'b1;
    checks++; if (bad != 0) $display("FAIL frz_hold: got %0d bad samples expected 0", bad); else passed++;
    checks++; if (chg_or !== 8'h00) $display("FAIL frz_chg: got %h expected 00", chg_or); else passed++;
    checks++; if (wrap_or !== 1'b0) $display("FAIL frz_wrap: got %b expected 0", wrap_or); else passed++;
    ticks(21);
    checks++; if (dut_if.out !== 8'h00) $display("FAIL frz_out_e95: got %h expected 00", dut_if.out); else passed++;
    tick();
    checks++; if (dut_if.out !== 8'h20) $display("FAIL frz_out_e96: got %h expected 20", dut_if.out); else passed++;
    checks++; if (dut_if.chg !== 8'h20) $display("FAIL frz_chg_e96: got %h expected 20", dut_if.chg); else passed++;
  endtask

  // cfg_ch=F must not touch ch7 (which would otherwise toggle early); then an
  // async reset mid-count clears everything at once.
  task automatic test_cfg_range_and_reset();
    apply_reset(8'h82);
    ticks(20);
    dut_if.cfg_wr = 1'b1;
    dut_if.cfg_ch = 4'hF;
    dut_if.cfg_filter = 16'd0;
    tick();
    dut_if.cfg_wr = 1'b0;
    ticks(26);
    checks++; if (dut_if.out !== 8'h00) $display("FAIL rng_out_e47: got %h expected 00", dut_if.out); else passed++;
    tick();
    checks++; if (dut_if.out !== 8'h80) $display("FAIL rng_out_e48: got %h expected 80", dut_if.out); else passed++;
    checks++; if (dut_if.chg !== 8'h80) $display("FAIL rng_chg_e48: got %h expected 80", dut_if.chg); else passed++;
    checks++; if (dut_if.scan_wrap !== 1'b1) $display("FAIL rng_wrap_e48: got %b expected 1", dut_if.scan_wrap); else passed++;
    #2 reset_n = 1'b0;
    exp_scan = 0;
    #1;
    checks++; if (dut_if.out !== 8'h00) $display("FAIL arst_out: got %h expected 00", dut_if.out); else passed++;
    checks++; if (dut_if.chg !== 8'h00) $display("FAIL arst_chg: got %h expected 00", dut_if.chg); else passed++;
    checks++; if (dut_if.scan_wrap !== 1'b0) $display("FAIL arst_wrap: got %b expected 0", dut_if.scan_wrap); else passed++;
    checks++; if (dut_if.scan_ch !== 4'd0) $display("FAIL arst_scan_ch: got %0d expected 0", dut_if.scan_ch); else passed++;
    tick();
    tick();
    reset_n = 1'b1;
    ticks(47);
    checks++; if (dut_if.out !== 8'h00) $display("FAIL arst_relearn_e47: got %h expected 00", dut_if.out); else passed++;
    tick();
    checks++; if (dut_if.out !== 8'h80) $display("FAIL arst_relearn_e48: got %h expected 80", dut_if.out); else passed++;
  endtask

  initial begin
    reset_n = 1'b1;
    test_reset();
    test_power_up_filter();
    test_glitch_reject();
    test_zero_filter();
    test_cfg_collision();
    test_en_freeze();
    test_cfg_range_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
